code_entry_checker: RTL and testbench
=====================================

Name: code_entry_checker

Overview:
- Front end of the lock/display path. Samples four raw push-buttons, debounces and edge-detects them, and collects a CODE_LEN-symbol entry.
- Compares the entry against a stored code and drives the `success`/`error` levels consumed by the seven-segment display top.
- Each result is held for HOLD_CYCLES, then the block returns to idle.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz).
- CODE_LEN, 4: number of symbols per entry, range 1..7.
- CODE, 8'b11_10_01_00: expected code, 2 bits per symbol; symbol 0 in bits [1:0]. Width is 2*CODE_LEN.
- HOLD_CYCLES, 100_000_000: cycles `success` or `error` stays high.
- TIMEOUT_CYCLES, 500_000_000: idle cycles allowed between symbols before the entry is aborted.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- reset_in  in  1  synchronous, active-high reset.
- btn  in  4  raw asynchronous buttons; btn[i] encodes symbol i.
- success  out  1  high for HOLD_CYCLES after a correct entry.
- error  out  1  high for HOLD_CYCLES after a wrong entry or a timeout.
- busy  out  1  high in any state other than IDLE.
- digits_entered  out  3  count of symbols accepted in the current entry.
- locked  out  1  lockout indicator; tied 0 without LOCKOUT_EN.

Behaviour:
- Reset:
  - reset_in is sampled on the rising edge of CLK100MHZ; it is synchronous and active-high.
  - Outputs reset to success=0, error=0, busy=0, digits_entered=0, locked=0.
  - State goes to IDLE; all counters, the shift register, the bad flag and the debounced levels clear to 0.
  - Reset asserted mid-operation aborts the entry or hold immediately, with no result pulse.
- Input conditioning:
  - Each btn bit passes through a 2-FF synchroniser, then a debouncer.
  - Debounced level changes only after DEBOUNCE_CYCLES consecutive cycles in which the synchronised level differs from it. Any bounce restarts the count.
  - A press event is a debounced 0->1 transition, lasting one cycle. Releases are ignored.
- Symbol capture:
  - Exactly one press event in a cycle: symbol = index, 2 bits.
  - More than one press event in the same cycle: the symbol counts, and the sticky `bad` flag is set.
- FSM states: IDLE, ENTRY, CHECK, SHOW_OK, SHOW_ERR, plus LOCKED when the optional feature is compiled in.
  - IDLE: a press stores the symbol, sets digits_entered=1 and moves to ENTRY. If CODE_LEN=1, it moves straight to CHECK.
  - ENTRY: each press stores the symbol and increments digits_entered. The timeout counter resets on every press.
    - The press that makes digits_entered reach CODE_LEN moves to CHECK.
    - If the timeout counter reaches TIMEOUT_CYCLES-1 with no press, go to SHOW_ERR.
  - CHECK: one cycle. Go to SHOW_OK if the entry equals CODE and bad=0; otherwise SHOW_ERR.
  - SHOW_OK / SHOW_ERR:
    - success (respectively error) is high for exactly HOLD_CYCLES cycles, then the block goes to IDLE and clears digits_entered.
    - All presses are ignored during the hold.
- Latency: if the last symbol's press event is in cycle N, CHECK is cycle N+1 and success/error rise at N+2.
- success and error are registered and never high together.
- Counter widths use $clog2 of the parameter. No counter wraps: each saturates at its terminal count and is cleared by the state transition.

Optional Feature:
- Macro: LOCKOUT_EN.
- With the macro:
  - A 2-bit consecutive-failure counter increments on each SHOW_ERR entry and clears on SHOW_OK.
  - On the third failure, the end of SHOW_ERR goes to LOCKED instead of IDLE.
  - LOCKED: locked=1, busy=1, presses ignored for 4*HOLD_CYCLES; then go to IDLE and clear the counter.
  - reset_in clears the counter and exits LOCKED.
- Without the macro: no LOCKED state, no failure counter, locked is constant 0.

Decomposition:
- Package yoda_pkg holds:
  - the state enum typedef;
  - SYM_W=2 and NUM_BTN=4;
  - the LOCK_FAILS=3 and LOCK_MULT=4 constants.
- Sub-module btn_debounce contains one button's synchroniser, debounce counter and rising-edge pulse, parameterised by DEBOUNCE_CYCLES. It is instantiated 4 times.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, TIMEOUT_CYCLES=100):
- Reset, then press btn 0,1,2,3 in order, each clean for 10 cycles -> success high for exactly 20 cycles, starting 2 cycles after the 4th press event; error stays 0; then busy=0 and digits_entered=0.
- Press 0,1,3,3 -> error high for 20 cycles, success 0.
- btn[1] bounces 0/1 every 2 cycles for 12 cycles, then holds at 1 -> exactly one press event, digits_entered=1.
- btn[0] and btn[2] pressed in the same cycle, then 1,2,3 -> error despite the other symbols matching the code.
- Two symbols entered, then no input for 100 cycles -> error asserted, digits_entered cleared after the hold. Separately, reset_in pulsed mid-SHOW_OK -> success drops on the next edge and busy=0.
- LOCKOUT_EN: three wrong entries -> locked=1 for 80 cycles after the 3rd error hold; a correct code entered during that time is ignored; after unlock, the correct code -> success.

Source files
------------

// File: rtl/yoda_pkg.sv
// Shared types and constants for the code-entry front end.
// LOCKOUT_EN adds the LOCKED state to the FSM encoding.
package yoda_pkg;

    localparam int unsigned SYM_W      = 2;
    localparam int unsigned NUM_BTN    = 4;
    localparam int unsigned LOCK_FAILS = 3;
    localparam int unsigned LOCK_MULT  = 4;

    typedef enum logic [2:0] {
        StIdle,
        StEntry,
        StCheck,
        StShowOk,
        StShowErr
`ifdef LOCKOUT_EN
        , StLocked
`endif
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchroniser, debounce counter and a one-cycle
// pulse on each accepted 0->1 level change.
module btn_debounce
    import yoda_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_in,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset_in) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= 1'b0;
            // Any cycle agreeing with the accepted level restarts the count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/code_entry_checker.sv
// Collects CODE_LEN debounced button symbols, compares them with CODE and
// holds success/error for HOLD_CYCLES. Optional lockout: define LOCKOUT_EN.
module code_entry_checker
    import yoda_pkg::*;
#(
    parameter int unsigned           DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned           CODE_LEN        = 4,
    parameter logic [2*CODE_LEN-1:0] CODE            = 8'b11_10_01_00,
    parameter int unsigned           HOLD_CYCLES     = 100_000_000,
    parameter int unsigned           TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic               CLK100MHZ,
    input  logic               reset_in,
    input  logic [NUM_BTN-1:0] btn,
    output logic               success,
    output logic               error,
    output logic               busy,
    output logic [2:0]         digits_entered,
    output logic               locked
);

`ifdef LOCKOUT_EN
    localparam int unsigned HW = cnt_w(LOCK_MULT * HOLD_CYCLES);
`else
    localparam int unsigned HW = cnt_w(HOLD_CYCLES);
`endif
    localparam int unsigned TW = cnt_w(TIMEOUT_CYCLES);
    localparam int unsigned EW = SYM_W * CODE_LEN;

    state_t             state;
    logic [NUM_BTN-1:0] press;
    logic [SYM_W-1:0]   sym;
    logic               any_press;
    logic               multi_press;
    logic [EW-1:0]      entry;
    logic [EW-1:0]      entry_shift;
    logic               bad;
    logic [TW-1:0]      tmo;
    logic [HW-1:0]      hold;
`ifdef LOCKOUT_EN
    logic [1:0]         fails;
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (CLK100MHZ),
            .reset_in(reset_in),
            .btn_raw (btn[i]),
            .press   (press[i])
        );
    end

    // Lowest pressed index wins; simultaneous presses are flagged via bad.
    always_comb begin
        sym = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (press[i]) sym = SYM_W'(i);
        end
        any_press   = |press;
        multi_press = |(press & (press - 1'b1));
    end

    // Newest symbol enters at the top so symbol 0 ends up in bits [1:0].
    if (CODE_LEN == 1) begin : g_shift_one
        assign entry_shift = sym;
    end else begin : g_shift_many
        assign entry_shift = {sym, entry[EW-1:SYM_W]};
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset_in) begin
            state          <= StIdle;
            entry          <= '0;
            bad            <= 1'b0;
            tmo            <= '0;
            hold           <= '0;
            success        <= 1'b0;
            error          <= 1'b0;
            busy           <= 1'b0;
            digits_entered <= '0;
`ifdef LOCKOUT_EN
            fails          <= '0;
            locked         <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_press) begin
                        entry          <= entry_shift;
                        bad            <= multi_press;
                        digits_entered <= 3'd1;
                        tmo            <= '0;
                        busy           <= 1'b1;
                        state          <= (CODE_LEN == 1) ? StCheck : StEntry;
                    end
                end
                StEntry: begin
                    if (any_press) begin
                        entry          <= entry_shift;
                        bad            <= bad | multi_press;
                        digits_entered <= digits_entered + 3'd1;
                        tmo            <= '0;
                        if (digits_entered == 3'(CODE_LEN - 1)) state <= StCheck;
                    end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                        state <= StShowErr;
                        error <= 1'b1;
                        hold  <= '0;
`ifdef LOCKOUT_EN
                        fails <= (fails == 2'(LOCK_FAILS)) ? fails : fails + 2'd1;
`endif
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                StCheck: begin
                    hold <= '0;
                    if (entry == CODE && !bad) begin
                        state   <= StShowOk;
                        success <= 1'b1;
`ifdef LOCKOUT_EN
                        fails   <= '0;
`endif
                    end else begin
                        state <= StShowErr;
                        error <= 1'b1;
`ifdef LOCKOUT_EN
                        fails <= (fails == 2'(LOCK_FAILS)) ? fails : fails + 2'd1;
`endif
                    end
                end
                StShowOk: begin
                    if (hold == HW'(HOLD_CYCLES - 1)) begin
                        state          <= StIdle;
                        success        <= 1'b0;
                        busy           <= 1'b0;
                        digits_entered <= '0;
                        hold           <= '0;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                StShowErr: begin
                    if (hold == HW'(HOLD_CYCLES - 1)) begin
                        error          <= 1'b0;
                        digits_entered <= '0;
                        hold           <= '0;
`ifdef LOCKOUT_EN
                        if (fails == 2'(LOCK_FAILS)) begin
                            state  <= StLocked;
                            locked <= 1'b1;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
`else
                        state <= StIdle;
                        busy  <= 1'b0;
`endif
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
`ifdef LOCKOUT_EN
                StLocked: begin
                    if (hold == HW'(LOCK_MULT * HOLD_CYCLES - 1)) begin
                        state  <= StIdle;
                        locked <= 1'b0;
                        busy   <= 1'b0;
                        fails  <= '0;
                        hold   <= '0;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

`ifndef LOCKOUT_EN
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_code_entry_checker.sv
// Directed bench for code_entry_checker with short debounce/hold/timeout.
// Define LOCKOUT_EN to also exercise the lockout scenario.
module tb_code_entry_checker;

    localparam int unsigned DB   = 4;
    localparam int unsigned HOLD = 20;
    localparam int unsigned TMO  = 100;

    logic       clk;
    logic       reset_in;
    logic [3:0] btn;
    logic       success;
    logic       error;
    logic       busy;
    logic [2:0] digits_entered;
    logic       locked;

    int n_cmp;
    int n_fail;

    code_entry_checker #(
        .DEBOUNCE_CYCLES(DB),
        .CODE_LEN       (4),
        .CODE           (8'b11_10_01_00),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK100MHZ     (clk),
        .reset_in      (reset_in),
        .btn           (btn),
        .success       (success),
        .error         (error),
        .busy          (busy),
        .digits_entered(digits_entered),
        .locked        (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clean press: held 10 cycles, released 10 cycles.
    task automatic press(input logic [3:0] mask);
        btn = mask;
        repeat (10) tick();
        btn = 4'b0;
        repeat (10) tick();
    endtask

    // Hold mask until digits_entered reaches want, then release at once.
    task automatic press_until(input logic [3:0] mask, input logic [2:0] want, output bit ok);
        int k;
        btn = mask;
        k = 0;
        while (digits_entered != want && k < 20) begin
            tick();
            k++;
        end
        ok = (digits_entered == want);
        btn = 4'b0;
    endtask

    task automatic pulse_reset();
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        btn = 4'b0;
        repeat (3) tick();
        n_cmp++; if (success !== 1'b0) begin n_fail++; $display("FAIL reset_success: got %b want 0", success); end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (digits_entered !== 3'd0) begin n_fail++; $display("FAIL reset_digits: got %0d want 0", digits_entered); end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
        reset_in = 1'b0;
        tick();
    endtask

    task automatic test_correct_code();
        bit ok;
        bit saw_err;
        int hi;
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        press_until(4'b1000, 3'd4, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL ok_fourth_press: digits %0d want 4", digits_entered); end
        // Cycle after the last press event is CHECK.
        n_cmp++; if (success !== 1'b0) begin n_fail++; $display("FAIL ok_check_cycle: success %b want 0", success); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ok_busy: got %b want 1", busy); end
        tick();
        n_cmp++; if (success !== 1'b1) begin n_fail++; $display("FAIL ok_rise: success %b want 1", success); end
        hi = 0;
        saw_err = 1'b0;
        while (success === 1'b1 && hi < 40) begin
            if (error !== 1'b0 || locked !== 1'b0) saw_err = 1'b1;
            hi++;
            tick();
        end
        n_cmp++; if (hi != HOLD) begin n_fail++; $display("FAIL ok_hold_len: got %0d want %0d", hi, HOLD); end
        n_cmp++; if (saw_err) begin n_fail++; $display("FAIL ok_no_error: error/locked seen 1 want 0"); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ok_idle_busy: got %b want 0", busy); end
        n_cmp++; if (digits_entered !== 3'd0) begin n_fail++; $display("FAIL ok_idle_digits: got %0d want 0", digits_entered); end
    endtask

    task automatic test_wrong_code();
        bit ok;
        bit saw_ok;
        int hi;
        press(4'b0001);
        press(4'b0010);
        press(4'b1000);
        press_until(4'b1000, 3'd4, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL bad_fourth_press: digits %0d want 4", digits_entered); end
        tick();
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL bad_rise: error %b want 1", error); end
        hi = 0;
        saw_ok = 1'b0;
        while (error === 1'b1 && hi < 40) begin
            if (success !== 1'b0) saw_ok = 1'b1;
            hi++;
            tick();
        end
        n_cmp++; if (hi != HOLD) begin n_fail++; $display("FAIL bad_hold_len: got %0d want %0d", hi, HOLD); end
        n_cmp++; if (saw_ok) begin n_fail++; $display("FAIL bad_no_success: success seen 1 want 0"); end
        n_cmp++; if (digits_entered !== 3'd0) begin n_fail++; $display("FAIL bad_idle_digits: got %0d want 0", digits_entered); end
    endtask

    task automatic test_bounce();
        bit ok;
        for (int i = 0; i < 12; i++) begin
            btn = ((i / 2) % 2 == 0) ? 4'b0010 : 4'b0000;
            tick();
        end
        n_cmp++; if (digits_entered !== 3'd0) begin n_fail++; $display("FAIL bounce_no_event: digits %0d want 0", digits_entered); end
        press_until(4'b0010, 3'd1, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL bounce_event: digits %0d want 1", digits_entered); end
        repeat (15) tick();
        n_cmp++; if (digits_entered !== 3'd1) begin n_fail++; $display("FAIL bounce_single: digits %0d want 1", digits_entered); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bounce_busy: got %b want 1", busy); end
        pulse_reset();
    endtask

    task automatic test_multi_press();
        bit ok;
        bit saw_ok;
        int hi;
        press(4'b0101);
        press(4'b0010);
        press(4'b0100);
        press_until(4'b1000, 3'd4, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL multi_fourth_press: digits %0d want 4", digits_entered); end
        tick();
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL multi_error: error %b want 1", error); end
        hi = 0;
        saw_ok = 1'b0;
        while (error === 1'b1 && hi < 40) begin
            if (success !== 1'b0) saw_ok = 1'b1;
            hi++;
            tick();
        end
        n_cmp++; if (saw_ok || hi != HOLD) begin n_fail++; $display("FAIL multi_hold: success_seen %b len %0d want 0/%0d", saw_ok, hi, HOLD); end
    endtask

    task automatic test_timeout();
        bit ok;
        int k;
        int hi;
        press(4'b0001);
        press_until(4'b0010, 3'd2, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL tmo_second_press: digits %0d want 2", digits_entered); end
        k = 0;
        while (error !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        n_cmp++; if (k != TMO) begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d", k, TMO); end
        n_cmp++; if (digits_entered !== 3'd2) begin n_fail++; $display("FAIL tmo_digits_held: got %0d want 2", digits_entered); end
        hi = 0;
        while (error === 1'b1 && hi < 40) begin
            hi++;
            tick();
        end
        n_cmp++; if (hi != HOLD) begin n_fail++; $display("FAIL tmo_hold_len: got %0d want %0d", hi, HOLD); end
        n_cmp++; if (digits_entered !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: digits %0d busy %b want 0/0", digits_entered, busy); end
    endtask

    task automatic test_reset_mid_ok();
        bit ok;
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        press_until(4'b1000, 3'd4, ok);
        tick();
        repeat (5) tick();
        n_cmp++; if (!ok || success !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: success %b want 1", success); end
        reset_in = 1'b1;
        tick();
        n_cmp++; if (success !== 1'b0) begin n_fail++; $display("FAIL rst_mid_success: got %b want 0", success); end
        n_cmp++; if (busy !== 1'b0 || digits_entered !== 3'd0) begin n_fail++; $display("FAIL rst_mid_idle: busy %b digits %0d want 0/0", busy, digits_entered); end
        reset_in = 1'b0;
        repeat (3) tick();
        n_cmp++; if (success !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_pulse: success %b error %b want 0/0", success, error); end
    endtask

`ifdef LOCKOUT_EN
    task automatic test_lockout();
        bit ok;
        bit moved;
        int k;
        int lk;
        pulse_reset();
        for (int r = 0; r < 3; r++) begin
            press(4'b0001);
            press(4'b0010);
            press(4'b1000);
            press(4'b1000);
            k = 0;
            while (error === 1'b1 && k < 60) begin
                tick();
                k++;
            end
            if (r < 2) begin
                n_cmp++; if (busy !== 1'b0 || locked !== 1'b0) begin n_fail++; $display("FAIL lock_early_%0d: busy %b locked %b want 0/0", r, busy, locked); end
            end
        end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_enter: locked %b want 1", locked); end
        lk = 0;
        moved = 1'b0;
        while (locked === 1'b1 && lk < 200) begin
            btn = ((lk % 20) < 10) ? (4'b0001 << ((lk / 20) % 4)) : 4'b0000;
            if (digits_entered !== 3'd0 || busy !== 1'b1) moved = 1'b1;
            tick();
            lk++;
        end
        btn = 4'b0;
        n_cmp++; if (lk != 4 * HOLD) begin n_fail++; $display("FAIL lock_len: got %0d want %0d", lk, 4 * HOLD); end
        n_cmp++; if (moved) begin n_fail++; $display("FAIL lock_ignore: presses accepted while locked"); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lock_exit_busy: got %b want 0", busy); end
        repeat (10) tick();
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        press_until(4'b1000, 3'd4, ok);
        tick();
        n_cmp++; if (!ok || success !== 1'b1) begin n_fail++; $display("FAIL lock_after_ok: success %b want 1", success); end
    endtask
`endif

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        reset_in = 1'b1;
        btn      = 4'b0;
        test_reset();
        test_correct_code();
        test_wrong_code();
        test_bounce();
        test_multi_press();
        test_timeout();
        test_reset_mid_ok();
`ifdef LOCKOUT_EN
        test_lockout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
